// File: rtl/bt_frame_tx_arbiter_pkg.sv
// Shared types and constants for the Bluetooth frame transmit arbiter.
package bt_frame_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHdr  = 3'd1,
    StType = 3'd2,
    StPay  = 3'd3,
    StSum  = 3'd4
  } state_e;

  localparam logic [7:0]  DefHeaderByte = 8'h55;
  localparam logic [7:0]  DefTypeBase   = 8'h50;
  localparam int unsigned GrantIdW      = 3;

  // Header + type + payload + checksum.
  function automatic int unsigned frame_bytes(input int unsigned payload_bytes);
    return payload_bytes + 3;
  endfunction

endpackage

// File: rtl/bt_frame_tx_arbiter_if.sv
// Requester and request-FIFO handshake bundle for bt_frame_tx_arbiter.
interface bt_frame_tx_arbiter_if
  import bt_frame_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned PAYLOAD_BYTES = 8
);

  logic [NUM_REQ*PAYLOAD_BYTES*8-1:0] req_data_i;
  logic [NUM_REQ-1:0]                 req_vld_i;
  logic [NUM_REQ-1:0]                 req_rdy_o;
  logic [7:0]                         fifo_data_o;
  logic                               fifo_data_o_vld;
  logic                               fifo_data_o_rdy;
  logic                               busy_o;
  logic [GrantIdW-1:0]                grant_id_o;
  logic [15:0]                        frame_cnt_o;

  // Arbiter side.
  modport master (
    input  req_data_i, req_vld_i, fifo_data_o_rdy,
    output req_rdy_o, fifo_data_o, fifo_data_o_vld, busy_o, grant_id_o, frame_cnt_o
  );

  // Requester / FIFO environment side.
  modport slave (
    output req_data_i, req_vld_i, fifo_data_o_rdy,
    input  req_rdy_o, fifo_data_o, fifo_data_o_vld, busy_o, grant_id_o, frame_cnt_o
  );

endinterface

// File: rtl/bt_frame_tx_arbiter_rr.sv
// Combinational round-robin grant: first requester after ptr_i, wrapping.
module bt_frame_tx_arbiter_rr
  import bt_frame_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]  vld_i,
  input  logic [GrantIdW-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  gnt_oh_o,
  output logic [GrantIdW-1:0] gnt_idx_o,
  output logic                any_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IdxW'((32'(ptr_i) + i) % NUM_REQ);
      if (!any_o && vld_i[idx]) begin
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = GrantIdW'(idx);
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bt_frame_tx_arbiter.sv
// Round-robin arbiter that latches one payload and serialises it as a framed byte stream
// (header, type, payload, checksum) into the Bluetooth request FIFO.
module bt_frame_tx_arbiter
  import bt_frame_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned PAYLOAD_BYTES = 8,
  parameter logic [7:0]  HEADER_BYTE   = DefHeaderByte,
  parameter logic [7:0]  TYPE_BASE     = DefTypeBase
) (
  input logic                  clk,
  input logic                  rst,
  bt_frame_tx_arbiter_if.master bus
);

  localparam int unsigned    CntW    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PAYLOAD_BYTES - 1);

  state_e                          state_q, state_d;
  logic [GrantIdW-1:0]             ptr_q, ptr_d;
  logic [GrantIdW-1:0]             grant_q, grant_d;
  logic                            busy_q, busy_d;
  logic [PAYLOAD_BYTES-1:0][7:0]   payload_q, payload_d;
  logic [7:0]                      type_q, type_d;
  logic [7:0]                      sum_q, sum_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [15:0]                     frame_cnt_q, frame_cnt_d;

  logic [NUM_REQ-1:0]  gnt_oh;
  logic [GrantIdW-1:0] gnt_idx;
  logic                gnt_any;
  logic [7:0]          byte_out;
  logic                xfer;

  bt_frame_tx_arbiter_rr #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .vld_i    (bus.req_vld_i),
    .ptr_i    (ptr_q),
    .gnt_oh_o (gnt_oh),
    .gnt_idx_o(gnt_idx),
    .any_o    (gnt_any)
  );

  always_comb begin
    byte_out = '0;
    case (state_q)
      StHdr:   byte_out = HEADER_BYTE;
      StType:  byte_out = type_q;
      StPay:   byte_out = payload_q[cnt_q];
      StSum:   byte_out = sum_q;
      default: byte_out = '0;
    endcase
  end

  assign xfer                = bus.fifo_data_o_vld & bus.fifo_data_o_rdy;
  assign bus.fifo_data_o     = byte_out;
  assign bus.fifo_data_o_vld = (state_q != StIdle);
  // Gated by rst so the accept pulse drops in the same cycle reset is asserted.
  assign bus.req_rdy_o       = (state_q == StIdle && !rst) ? gnt_oh : '0;
  assign bus.busy_o          = busy_q;
  assign bus.grant_id_o      = grant_q;
  assign bus.frame_cnt_o     = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    payload_d   = payload_q;
    type_d      = type_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      StIdle: begin
        if (gnt_any) begin
          for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (gnt_oh[k]) payload_d = bus.req_data_i[k*PAYLOAD_BYTES*8 +: PAYLOAD_BYTES*8];
          end
          type_d  = TYPE_BASE + 8'(gnt_idx);
          ptr_d   = gnt_idx;
          grant_d = gnt_idx;
          busy_d  = 1'b1;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (xfer) begin
          sum_d   = sum_q + byte_out;
          state_d = StType;
        end
      end
      StType: begin
        if (xfer) begin
          sum_d   = sum_q + byte_out;
          cnt_d   = '0;
          state_d = StPay;
        end
      end
      StPay: begin
        if (xfer) begin
          sum_d = sum_q + byte_out;
          if (cnt_q == LastCnt) state_d = StSum;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      StSum: begin
        if (xfer) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= GrantIdW'(NUM_REQ - 1);
      grant_q     <= '0;
      busy_q      <= 1'b0;
      payload_q   <= '0;
      type_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      payload_q   <= payload_d;
      type_q      <= type_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_bt_frame_tx_arbiter.sv
// Scoreboard bench for bt_frame_tx_arbiter: a frame-level model predicts grants and byte streams.
module tb_bt_frame_tx_arbiter;
  import bt_frame_tx_arbiter_pkg::*;

  localparam int unsigned NumReq     = 2;
  localparam int unsigned Pb         = 8;
  localparam int unsigned FrameBytes = frame_bytes(Pb);
  localparam logic [7:0]  Hdr        = 8'h55;
  localparam logic [7:0]  TypeBase   = 8'h50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NumReq*Pb*8-1:0] req_data = '0;
  logic [NumReq-1:0]      req_vld  = '0;
  logic                   fifo_rdy = 1'b1;

  bt_frame_tx_arbiter_if #(.NUM_REQ(NumReq), .PAYLOAD_BYTES(Pb)) bus ();

  assign bus.req_data_i      = req_data;
  assign bus.req_vld_i       = req_vld;
  assign bus.fifo_data_o_rdy = fifo_rdy;

  bt_frame_tx_arbiter #(
    .NUM_REQ      (NumReq),
    .PAYLOAD_BYTES(Pb),
    .HEADER_BYTE  (Hdr),
    .TYPE_BASE    (TypeBase)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          accept_log[$];
  bit          model_busy  = 1'b0;
  int          model_ptr   = NumReq - 1;
  int          model_grant = 0;
  logic [15:0] model_frames = '0;
  int          done_total  = 0;
  int          cyc         = 0;
  bit          stalled     = 1'b0;
  logic [7:0]  stall_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and reference model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NumReq-1:0] exp_rdy;
    int                g;
    int                s;
    logic [7:0]        b;
    logic [7:0]        e;
    cyc++;
    if (rst) begin
      check("rst_outputs", {bus.req_rdy_o, bus.fifo_data_o_vld, bus.fifo_data_o, bus.busy_o,
                            5'(bus.grant_id_o), bus.frame_cnt_o}, '0);
      exp_q.delete();
      model_busy   = 1'b0;
      model_ptr    = NumReq - 1;
      model_grant  = 0;
      model_frames = '0;
      stalled      = 1'b0;
    end else begin
      check("busy", 32'(bus.busy_o), 32'(model_busy));
      check("grant_id", 32'(bus.grant_id_o), 32'(model_grant));
      check("frame_cnt", 32'(bus.frame_cnt_o), 32'(model_frames));
      if (!model_busy) begin
        exp_rdy = '0;
        g = -1;
        for (int i = 1; i <= int'(NumReq); i++) begin
          if (g < 0 && req_vld[(model_ptr + i) % NumReq]) g = (model_ptr + i) % NumReq;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_rdy", 32'(bus.req_rdy_o), 32'(exp_rdy));
        check("idle_vld", 32'(bus.fifo_data_o_vld), 32'd0);
        if (g >= 0) begin
          s = int'(Hdr) + int'(TypeBase) + g;
          exp_q.push_back(Hdr);
          exp_q.push_back(8'(int'(TypeBase) + g));
          for (int k = 0; k < int'(Pb); k++) begin
            b = req_data[(g*Pb + k)*8 +: 8];
            exp_q.push_back(b);
            s += int'(b);
          end
          exp_q.push_back(8'(s % 256));
          model_busy  = 1'b1;
          model_ptr   = g;
          model_grant = g;
          accept_log.push_back(cyc);
        end
      end else begin
        check("busy_req_rdy", 32'(bus.req_rdy_o), 32'd0);
        check("busy_vld", 32'(bus.fifo_data_o_vld), 32'd1);
        if (stalled) check("stall_data", 32'(bus.fifo_data_o), 32'(stall_data));
        if (bus.fifo_data_o_vld && fifo_rdy) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            check("extra_byte", 32'(bus.fifo_data_o_vld), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'(bus.fifo_data_o), 32'(e));
            if (exp_q.size() == 0) begin
              model_busy   = 1'b0;
              model_frames = model_frames + 16'd1;
              done_total++;
            end
          end
        end else begin
          stalled    = bus.fifo_data_o_vld;
          stall_data = bus.fifo_data_o;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n);
    int target;
    int budget;
    target = done_total + n;
    budget = n * 200;
    while (done_total < target && budget > 0) begin
      step(1);
      budget--;
    end
    check("frame_timeout", 32'(done_total >= target), 32'd1);
  endtask

  task automatic rand_payload(input int k);
    for (int b = 0; b < int'(Pb); b++) req_data[(k*Pb + b)*8 +: 8] = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Issue one frame request from requester k (one-cycle vld while idle).
  task automatic issue(input int k);
    req_vld    = '0;
    req_vld[k] = 1'b1;
    step(1);
    req_vld = '0;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);

    // Incrementing payload, FIFO always ready.
    for (int b = 0; b < int'(Pb); b++) req_data[b*8 +: 8] = 8'(b + 1);
    issue(0);
    wait_done(1);
    step(2);

    // Both requesters held: strict rotation with one idle cycle between frames.
    do_reset();
    rand_payload(0);
    rand_payload(1);
    accept_log.delete();
    req_vld = '1;
    wait_done(4);
    req_vld = '0;
    check("rotation_frames", 32'(accept_log.size()), 32'd4);
    for (int i = 1; i < accept_log.size(); i++)
      check("accept_spacing", 32'(accept_log[i] - accept_log[i-1]), 32'(FrameBytes + 1));
    step(2);

    // Toggling ready with a long stall mid-payload.
    rand_payload(0);
    req_vld = 2'b01;
    for (int k = 0; k < 300; k++) begin
      fifo_rdy = (k >= 8 && k < 28) ? 1'b0 : 1'(k % 2 == 0);
      step(1);
      req_vld = '0;
      if (!model_busy && k > 2) break;
    end
    fifo_rdy = 1'b1;
    check("toggle_frame_done", 32'(model_busy), 32'd0);
    step(2);

    // All-0xFF payload, then scrambled after accept.
    for (int b = 0; b < int'(Pb); b++) req_data[(Pb + b)*8 +: 8] = 8'hFF;
    issue(1);
    for (int k = 0; k < 4; k++) begin
      rand_payload(1);
      step(1);
    end
    wait_done(1);
    step(2);

    // Reset while payload byte 4 is on the bus.
    rand_payload(0);
    issue(0);
    step(6);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    req_vld = '1;
    step(1);
    req_vld = '0;
    check("post_reset_grant", 32'(model_grant), 32'd0);
    wait_done(1);
    check("post_reset_count", 32'(bus.frame_cnt_o), 32'd1);
    step(2);

    // Frame counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    model_frames = 16'hFFFF;
    step(2);
    release dut.frame_cnt_q;
    issue(1);
    wait_done(1);
    check("frame_cnt_wrap", 32'(bus.frame_cnt_o), 32'd0);
    step(2);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      req_vld  = NumReq'($urandom_range(0, (1 << NumReq) - 1));
      fifo_rdy = 1'($urandom % 4 != 0);
      for (int r = 0; r < int'(NumReq); r++) rand_payload(r);
      step(1);
    end
    req_vld  = '0;
    fifo_rdy = 1'b1;
    for (int k = 0; k < 50 && model_busy; k++) step(1);
    check("drain_idle", 32'(model_busy), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
